// File: rtl/mau_pkg.sv
// Shared definitions for the data-memory dump engine: FSM encoding, memory
// geometry and the word-index wrap helper.
package mau_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_NEXT = 3'd4,
    ST_CSUM = 3'd5
  } mau_state_e;

  localparam int MEM_WORDS = 4096;
  localparam int IDX_W     = 12;

  // Word index advance that wraps at the top of data memory.
  function automatic logic [IDX_W-1:0] idx_wrap_inc(input logic [IDX_W-1:0] idx,
                                                    input int words);
    if (int'(idx) >= words - 1) return '0;
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/mau_byte_serializer.sv
// Loads a 32-bit word and hands it out little-endian, one byte per
// valid/ready handshake; flags the handshake that moves the 4th byte.
module mau_byte_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic        send_i,
  input  logic        ready_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        last_o
);

  logic [31:0] shift_q;
  logic [1:0]  cnt_q;
  logic        fire;

  assign fire = send_i & ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (fire) begin
      cnt_q <= cnt_q + 2'd1;
    end
  end

  // Data path carries no reset; the output mux keeps tx_data at 0 whenever idle.
  always_ff @(posedge clk) begin
    if (load_i) begin
      shift_q <= data_i;
    end else if (fire) begin
      shift_q <= {8'h00, shift_q[31:8]};
    end
  end

  assign valid_o = send_i;
  assign data_o  = send_i ? shift_q[7:0] : 8'h00;
  assign last_o  = fire & (cnt_q == 2'd3);

endmodule

// File: rtl/mau_mem_dump.sv
// Data-memory readback engine: streams a word range as little-endian bytes
// while the CPU is held off. Optional trailing XOR checksum: MAU_MEM_DUMP_CHECKSUM_EN.
module mau_mem_dump #(
  parameter int MEM_WORDS = mau_pkg::MEM_WORDS,
  parameter int CNT_W     = 13
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             alive,
  input  logic             start,
  input  logic [31:0]      start_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             mem_clk_en,
  output logic [31:0]      mem_address,
  output logic             mem_wren,
  output logic [31:0]      mem_data_write,
  input  logic [31:0]      mem_data_read,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic             abort
);

  import mau_pkg::*;

  mau_state_e       state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;

  logic             ser_load;
  logic [31:0]      ser_data;
  logic             ser_send;
  logic             ser_last;

  logic             unused_addr_bits;
  assign unused_addr_bits = ^{start_addr[31:IDX_W+2], start_addr[1:0]};

`ifdef MAU_MEM_DUMP_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_ff @(posedge clk) begin
    csum_q <= csum_d;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      index_q     <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    ser_load    = 1'b0;
    ser_data    = mem_data_read;
`ifdef MAU_MEM_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    // CPU reclaiming memory wins over everything, including completion.
    if (state_q != ST_IDLE && alive) begin
      state_d = ST_IDLE;
      abort_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !alive) begin
            index_d     = start_addr[IDX_W+1:2];
            remaining_d = word_count;
`ifdef MAU_MEM_DUMP_CHECKSUM_EN
            csum_d      = '0;
            if (word_count == '0) begin
              ser_load = 1'b1;
              ser_data = '0;
              state_d  = ST_CSUM;
            end else begin
              state_d = ST_REQ;
            end
`else
            if (word_count == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_REQ;
            end
`endif
          end
        end
        ST_REQ: begin
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          ser_load = 1'b1;
`ifdef MAU_MEM_DUMP_CHECKSUM_EN
          csum_d   = csum_q ^ mem_data_read;
`endif
          state_d  = ST_SEND;
        end
        ST_SEND: begin
          if (ser_last) state_d = ST_NEXT;
        end
        ST_NEXT: begin
          remaining_d = remaining_q - CNT_W'(1);
          index_d     = idx_wrap_inc(index_q, MEM_WORDS);
          if (remaining_q == CNT_W'(1)) begin
`ifdef MAU_MEM_DUMP_CHECKSUM_EN
            ser_load = 1'b1;
            ser_data = csum_q;
            state_d  = ST_CSUM;
`else
            done_d  = 1'b1;
            state_d = ST_IDLE;
`endif
          end else begin
            state_d = ST_REQ;
          end
        end
`ifdef MAU_MEM_DUMP_CHECKSUM_EN
        ST_CSUM: begin
          if (ser_last) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

`ifdef MAU_MEM_DUMP_CHECKSUM_EN
  assign ser_send = (state_q == ST_SEND) || (state_q == ST_CSUM);
`else
  assign ser_send = (state_q == ST_SEND);
`endif

  mau_byte_serializer u_ser (
    .clk     (clk),
    .rst_n   (reset_n),
    .load_i  (ser_load),
    .data_i  (ser_data),
    .send_i  (ser_send),
    .ready_i (tx_ready),
    .data_o  (tx_data),
    .valid_o (tx_valid),
    .last_o  (ser_last)
  );

  assign mem_clk_en     = (state_q == ST_REQ);
  assign mem_address    = {{(30 - IDX_W){1'b0}}, index_q, 2'b00};
  assign mem_wren       = 1'b0;
  assign mem_data_write = '0;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign abort          = abort_q;

endmodule

// File: tb/tb_mau_mem_dump.sv
// Directed bench for mau_mem_dump with a 1-cycle-latency RAM model.
module tb_mau_mem_dump;

  localparam int CNT_W = 13;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             alive = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      start_addr = '0;
  logic [CNT_W-1:0] word_count = '0;
  logic             tx_ready = 1'b0;
  logic             mem_clk_en, mem_wren, tx_valid, busy, done, abort;
  logic [31:0]      mem_address, mem_data_write, mem_data_read;
  logic [7:0]       tx_data;

  logic [31:0] mem [0:4095];
  logic [31:0] q_r;

  int checks = 0;
  int errors = 0;
  logic [7:0]  rx_q[$];
  logic [31:0] addr_q[$];
  int done_cnt = 0;
  int abort_cnt = 0;
  int wren_cnt = 0;

  mau_mem_dump #(.MEM_WORDS(4096), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .alive          (alive),
    .start          (start),
    .start_addr     (start_addr),
    .word_count     (word_count),
    .mem_clk_en     (mem_clk_en),
    .mem_address    (mem_address),
    .mem_wren       (mem_wren),
    .mem_data_write (mem_data_write),
    .mem_data_read  (mem_data_read),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .busy           (busy),
    .done           (done),
    .abort          (abort)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clk_en) q_r <= mem[mem_address[13:2]];
  end
  assign mem_data_read = q_r;

  always @(posedge clk) begin
    if (reset_n) begin
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (mem_clk_en) addr_q.push_back(mem_address);
      if (done) done_cnt++;
      if (abort) abort_cnt++;
      if (mem_wren || mem_data_write != 32'h0) wren_cnt++;
    end
  end

  task automatic clear_logs();
    rx_q.delete();
    addr_q.delete();
    done_cnt  = 0;
    abort_cnt = 0;
    wren_cnt  = 0;
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [CNT_W-1:0] n);
    @(negedge clk);
    start_addr = a;
    word_count = n;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b want 0", abort); end
    checks++; if (mem_clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en: got %b want 0", mem_clk_en); end
    checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL reset_address: got %h want 0", mem_address); end
    checks++; if (mem_wren !== 1'b0 || mem_data_write !== 32'h0) begin errors++; $display("FAIL reset_write_port: got %b/%h want 0/0", mem_wren, mem_data_write); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_normal();
    logic [7:0] exp[$];
    int k;
    exp = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
`ifdef MAU_MEM_DUMP_CHECKSUM_EN
    exp.push_back(8'h99); exp.push_back(8'hFF); exp.push_back(8'h99); exp.push_back(8'hBB);
`endif
    clear_logs();
    tx_ready = 1'b1;
    pulse_start(32'h100, 13'd2);
    for (k = 1; k <= 60; k++) begin
      if (done) break;
      @(negedge clk);
    end
`ifdef MAU_MEM_DUMP_CHECKSUM_EN
    checks++; if (k != 19) begin errors++; $display("FAIL normal_done_cycle: got %0d want 19", k); end
`else
    checks++; if (k != 15) begin errors++; $display("FAIL normal_done_cycle: got %0d want 15", k); end
`endif
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL normal_busy_at_done: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    checks++; if (rx_q.size() != exp.size()) begin errors++; $display("FAIL normal_byte_count: got %0d want %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL normal_byte[%0d]: got %h want %h", i, rx_q[i], exp[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL normal_done_pulses: got %0d want 1", done_cnt); end
    checks++; if (wren_cnt != 0) begin errors++; $display("FAIL normal_write_seen: got %0d want 0", wren_cnt); end
    checks++; if (addr_q.size() != 2) begin errors++; $display("FAIL normal_read_count: got %0d want 2", addr_q.size()); end
    else begin
      checks++; if (addr_q[0] !== 32'h100 || addr_q[1] !== 32'h104) begin errors++; $display("FAIL normal_addr_seq: got %h %h want 00000100 00000104", addr_q[0], addr_q[1]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[$];
    bit stalled_prev;
    logic [7:0] prev_data;
    exp = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
`ifdef MAU_MEM_DUMP_CHECKSUM_EN
    exp.push_back(8'h99); exp.push_back(8'hFF); exp.push_back(8'h99); exp.push_back(8'hBB);
`endif
    clear_logs();
    tx_ready = 1'b0;
    stalled_prev = 1'b0;
    prev_data = 8'h00;
    pulse_start(32'h100, 13'd2);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done) break;
      if (stalled_prev) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          errors++; $display("FAIL bp_stable: got valid=%b data=%h want valid=1 data=%h", tx_valid, tx_data, prev_data);
        end
      end
      tx_ready = (cyc % 3 == 0);
      stalled_prev = tx_valid && !tx_ready;
      prev_data = tx_data;
      @(negedge clk);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_timeout: got done=%b want 1", done); end
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rx_q.size() != exp.size()) begin errors++; $display("FAIL bp_byte_count: got %0d want %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL bp_byte[%0d]: got %h want %h", i, rx_q[i], exp[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_pulses: got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp[$];
    bit ok;
    exp = '{8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h04, 8'h03, 8'h02, 8'h01};
`ifdef MAU_MEM_DUMP_CHECKSUM_EN
    exp.push_back(8'h09); exp.push_back(8'hF3); exp.push_back(8'hFC); exp.push_back(8'hCB);
`endif
    clear_logs();
    tx_ready = 1'b1;
    pulse_start(32'h3FFC, 13'd2);
    run_until_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: got done=0 want 1"); end
    repeat (2) @(negedge clk);
    checks++; if (addr_q.size() != 2) begin errors++; $display("FAIL wrap_read_count: got %0d want 2", addr_q.size()); end
    else begin
      checks++; if (addr_q[0] !== 32'h3FFC || addr_q[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr_seq: got %h %h want 00003ffc 00000000", addr_q[0], addr_q[1]); end
    end
    checks++; if (rx_q.size() != exp.size()) begin errors++; $display("FAIL wrap_byte_count: got %0d want %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL wrap_byte[%0d]: got %h want %h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_zero_count();
    int k;
    bit valid_seen;
    clear_logs();
    tx_ready = 1'b1;
    valid_seen = 1'b0;
    pulse_start(32'h200, 13'd0);
    for (k = 1; k <= 20; k++) begin
      if (tx_valid) valid_seen = 1'b1;
      if (done) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
`ifdef MAU_MEM_DUMP_CHECKSUM_EN
    checks++; if (k != 5) begin errors++; $display("FAIL zero_done_cycle: got %0d want 5", k); end
    checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL zero_csum_bytes: got %0d want 4", rx_q.size()); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== 8'h00) begin errors++; $display("FAIL zero_csum_byte[%0d]: got %h want 00", i, rx_q[i]); end
    end
`else
    checks++; if (k != 1) begin errors++; $display("FAIL zero_done_cycle: got %0d want 1", k); end
    checks++; if (valid_seen) begin errors++; $display("FAIL zero_tx_valid: got 1 want 0"); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL zero_bytes: got %0d want 0", rx_q.size()); end
`endif
    checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL zero_reads: got %0d want 0", addr_q.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    bit ok;
    clear_logs();
    tx_ready = 1'b1;
    pulse_start(32'h100, 13'd2);
    for (int k = 0; k < 30; k++) begin
      if (rx_q.size() >= 2) break;
      @(negedge clk);
    end
    alive    = 1'b1;
    tx_ready = 1'b0;
    @(negedge clk);
    checks++; if (abort !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b want 1", abort); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL abort_tx_valid: got %b want 0", tx_valid); end
    checks++; if (mem_clk_en !== 1'b0) begin errors++; $display("FAIL abort_clk_en: got %b want 0", mem_clk_en); end
    repeat (3) @(negedge clk);
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL abort_width: got %b want 0", abort); end
    checks++; if (abort_cnt != 1) begin errors++; $display("FAIL abort_pulses: got %0d want 1", abort_cnt); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
    checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL abort_bytes: got %0d want 2", rx_q.size()); end
    alive    = 1'b0;
    tx_ready = 1'b1;
    clear_logs();
    pulse_start(32'h100, 13'd1);
    run_until_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_restart_timeout: got done=0 want 1"); end
    repeat (2) @(negedge clk);
`ifdef MAU_MEM_DUMP_CHECKSUM_EN
    checks++; if (rx_q.size() != 8) begin errors++; $display("FAIL abort_restart_bytes: got %0d want 8", rx_q.size()); end
`else
    checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL abort_restart_bytes: got %0d want 4", rx_q.size()); end
`endif
    if (rx_q.size() >= 4) begin
      checks++; if (rx_q[0] !== 8'h44 || rx_q[3] !== 8'h11) begin errors++; $display("FAIL abort_restart_data: got %h..%h want 44..11", rx_q[0], rx_q[3]); end
    end
    checks++; if (abort_cnt != 0) begin errors++; $display("FAIL abort_restart_abort: got %0d want 0", abort_cnt); end
  endtask

  task automatic test_ignored_start();
    bit ok;
    clear_logs();
    alive = 1'b1;
    pulse_start(32'h100, 13'd2);
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_alive_busy: got %b want 0", busy); end
    checks++; if (addr_q.size() != 0 || done_cnt != 0) begin errors++; $display("FAIL ign_alive_activity: got reads=%0d done=%0d want 0/0", addr_q.size(), done_cnt); end
    alive = 1'b0;
    tx_ready = 1'b1;
    clear_logs();
    pulse_start(32'h100, 13'd2);
    repeat (2) @(negedge clk);
    start_addr = 32'h3FFC;
    word_count = 13'd1;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    run_until_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_busy_timeout: got done=0 want 1"); end
    repeat (4) @(negedge clk);
    checks++; if (addr_q.size() != 2) begin errors++; $display("FAIL ign_busy_reads: got %0d want 2", addr_q.size()); end
    else begin
      checks++; if (addr_q[0] !== 32'h100 || addr_q[1] !== 32'h104) begin errors++; $display("FAIL ign_busy_addr: got %h %h want 00000100 00000104", addr_q[0], addr_q[1]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_busy_done: got %0d want 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    tx_ready = 1'b1;
    pulse_start(32'h100, 13'd2);
    repeat (3) @(negedge clk);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL rmid_in_send: got %b want 1", tx_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rmid_tx_data: got %h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL rmid_address: got %h want 0", mem_address); end
    checks++; if (mem_clk_en !== 1'b0 || done !== 1'b0 || abort !== 1'b0) begin errors++; $display("FAIL rmid_pulses: got clk_en=%b done=%b abort=%b want 0", mem_clk_en, done, abort); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (done_cnt != 0 || abort_cnt != 0) begin errors++; $display("FAIL rmid_no_pulse: got done=%0d abort=%0d want 0/0", done_cnt, abort_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle: got %b want 0", busy); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[64]   = 32'h11223344;
    mem[65]   = 32'hAABBCCDD;
    mem[4095] = 32'hCAFEF00D;
    mem[0]    = 32'h01020304;
    test_reset();
    test_normal();
    test_backpressure();
    test_wrap();
    test_zero_count();
    test_abort();
    test_ignored_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
